serial_packet_engine: RTL and testbench



---
 rtl/serial_packet_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_serial_packet_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_engine.sv
// serial_packet_engine
//
// Byte-to-packet layer between a UART byte receiver/transmitter pair and user
// logic.
//
// RX side: captures one byte per rising edge of i_rx_valid into a BYTES-wide
// shift word and counts the captured bytes. A packet is closed once the line
// has been idle for IDLE_BYTES byte times; closing pulses o_pkt_done and
// snapshots the word and the packet length.
//
// TX side: takes a multi-byte word and sends it byte by byte, MSB first, to
// the UART transmitter using its start/busy handshake.
//
// Optional build macro: SERIAL_PKT_ECHO_EN
//   When defined, a closed packet is echoed back on TX if the engine is idle.
//   An i_tx_start in the same cycle takes priority over the echo.
//
// Ports
//   i_Clk, i_Rst_n           clock, asynchronous active-low reset
//   i_rx_valid, i_rx_data    receiver byte strobe/level and byte
//   o_rx_word                shift buffer, newest byte in [7:0]
//   o_rx_count               total captured bytes (wraps)
//   o_pkt_len                bytes in the open packet (saturates at 255)
//   o_pkt_done               one-cycle pulse when a packet closes
//   o_pkt_word, o_last_len   word and length snapshot at close
//   i_tx_start, i_tx_word,   request to send i_tx_len bytes of i_tx_word
//   i_tx_len                 (0 or more than BYTES means BYTES)
//   o_tx_ready               TX engine idle, start requests honoured
//   o_tx_done                one-cycle pulse after the last byte completes
//   o_tx_byte                byte presented to the transmitter
//   o_tx_byte_start          one-cycle start pulse to the transmitter
//   i_tx_busy                transmitter busy

module serial_packet_engine #(
    parameter int                  CLOCK_FREQUENCY = 50000000,
    parameter int                  BAUD            = 115200,
    parameter int                  BYTES           = 4,
    parameter int                  IDLE_BYTES      = 2,
    parameter logic [8*BYTES-1:0]  RESET_WORD      = 'h41
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    output logic [8*BYTES-1:0]   o_rx_word,
    output logic [7:0]           o_rx_count,
    output logic [7:0]           o_pkt_len,
    output logic                 o_pkt_done,
    output logic [8*BYTES-1:0]   o_pkt_word,
    output logic [7:0]           o_last_len,
    input  logic                 i_tx_start,
    input  logic [8*BYTES-1:0]   i_tx_word,
    input  logic [7:0]           i_tx_len,
    output logic                 o_tx_ready,
    output logic                 o_tx_done,
    output logic [7:0]           o_tx_byte,
    output logic                 o_tx_byte_start,
    input  logic                 i_tx_busy
);

    localparam int W         = 8 * BYTES;
    localparam int BYTE_TIME = 10 * CLOCK_FREQUENCY / BAUD;
    localparam int T_IDLE    = IDLE_BYTES * BYTE_TIME;
    localparam int TW        = (T_IDLE > 1) ? $clog2(T_IDLE + 1) : 1;
    localparam int IW        = (BYTES > 1) ? $clog2(BYTES) : 1;

    // ---------------------------------------------------------------- RX side
    logic           rx_valid_prev_reg;
    logic [W-1:0]   rx_word_reg;
    logic [7:0]     rx_count_reg;
    logic [7:0]     pkt_len_reg;
    logic           pkt_done_reg;
    logic [W-1:0]   pkt_word_reg;
    logic [7:0]     last_len_reg;
    logic [TW-1:0]  idle_timer_reg;

    logic           capture;
    logic           timeout;
    logic [W-1:0]   rx_word_shifted;

    assign capture = i_rx_valid & ~rx_valid_prev_reg;
    // The timer is one short of T here; the close lands on the T-th edge.
    assign timeout = (pkt_len_reg != 8'd0) && (idle_timer_reg == TW'(T_IDLE - 1));

    generate
        if (BYTES == 1) begin : g_single_byte
            assign rx_word_shifted = i_rx_data;
        end else begin : g_multi_byte
            assign rx_word_shifted = {rx_word_reg[W-9:0], i_rx_data};
        end
    endgenerate

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_valid_prev_reg <= 1'b0;
            rx_word_reg       <= RESET_WORD;
            rx_count_reg      <= 8'd0;
            pkt_len_reg       <= 8'd0;
            pkt_done_reg      <= 1'b0;
            pkt_word_reg      <= '0;
            last_len_reg      <= 8'd0;
            idle_timer_reg    <= '0;
        end else begin
            rx_valid_prev_reg <= i_rx_valid;
            pkt_done_reg      <= 1'b0;
            // A capture in the timeout cycle keeps the packet open.
            if (capture) begin
                rx_word_reg    <= rx_word_shifted;
                rx_count_reg   <= rx_count_reg + 8'd1;
                if (pkt_len_reg != 8'hFF) begin
                    pkt_len_reg <= pkt_len_reg + 8'd1;
                end
                idle_timer_reg <= '0;
            end else if (timeout) begin
                pkt_done_reg   <= 1'b1;
                pkt_word_reg   <= rx_word_reg;
                last_len_reg   <= pkt_len_reg;
                pkt_len_reg    <= 8'd0;
                idle_timer_reg <= '0;
            end else if (pkt_len_reg != 8'd0) begin
                idle_timer_reg <= idle_timer_reg + TW'(1);
            end
        end
    end

    assign o_rx_word  = rx_word_reg;
    assign o_rx_count = rx_count_reg;
    assign o_pkt_len  = pkt_len_reg;
    assign o_pkt_done = pkt_done_reg;
    assign o_pkt_word = pkt_word_reg;
    assign o_last_len = last_len_reg;

    // ---------------------------------------------------------------- TX side
    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_SEND    = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_t;

    tx_state_t      tx_state_reg, tx_state_next;
    logic [W-1:0]   tx_word_reg, tx_word_next;
    logic [IW-1:0]  tx_idx_reg, tx_idx_next;
    logic [7:0]     tx_byte_reg, tx_byte_next;
    logic           tx_byte_start_reg, tx_byte_start_next;
    logic           tx_done_reg, tx_done_next;

    logic           start_req;
    logic [W-1:0]   start_word;
    logic [7:0]     start_len;
    logic [7:0]     len_clamped;
    logic [IW-1:0]  idx_load;
    logic [7:0]     tx_bytes [BYTES];

`ifdef SERIAL_PKT_ECHO_EN
    // Echo a freshly closed packet; an explicit start in the same cycle wins.
    always_comb begin
        start_req  = i_tx_start | pkt_done_reg;
        start_word = i_tx_start ? i_tx_word : pkt_word_reg;
        start_len  = i_tx_start ? i_tx_len  : last_len_reg;
    end
`else
    assign start_req  = i_tx_start;
    assign start_word = i_tx_word;
    assign start_len  = i_tx_len;
`endif

    assign len_clamped = ((start_len == 8'd0) || (start_len > 8'(BYTES))) ? 8'(BYTES) : start_len;
    assign idx_load    = IW'(len_clamped - 8'd1);

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_tx_bytes
            assign tx_bytes[gi] = tx_word_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_state_reg      <= TX_IDLE;
            tx_word_reg       <= '0;
            tx_idx_reg        <= '0;
            tx_byte_reg       <= 8'd0;
            tx_byte_start_reg <= 1'b0;
            tx_done_reg       <= 1'b0;
        end else begin
            tx_state_reg      <= tx_state_next;
            tx_word_reg       <= tx_word_next;
            tx_idx_reg        <= tx_idx_next;
            tx_byte_reg       <= tx_byte_next;
            tx_byte_start_reg <= tx_byte_start_next;
            tx_done_reg       <= tx_done_next;
        end
    end

    always_comb begin
        tx_state_next      = tx_state_reg;
        tx_word_next       = tx_word_reg;
        tx_idx_next        = tx_idx_reg;
        tx_byte_next       = tx_byte_reg;
        tx_byte_start_next = 1'b0;
        tx_done_next       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (start_req) begin
                    tx_word_next  = start_word;
                    tx_idx_next   = idx_load;
                    tx_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!i_tx_busy) begin
                    tx_byte_next       = tx_bytes[tx_idx_reg];
                    tx_byte_start_next = 1'b1;
                    tx_state_next      = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (i_tx_busy) begin
                    tx_state_next = TX_WAIT_LO;
                end
            end
            TX_WAIT_LO: begin
                if (!i_tx_busy) begin
                    if (tx_idx_reg == '0) begin
                        tx_state_next = TX_IDLE;
                        tx_done_next  = 1'b1;
                    end else begin
                        tx_idx_next   = tx_idx_reg - IW'(1);
                        tx_state_next = TX_SEND;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign o_tx_ready      = (tx_state_reg == TX_IDLE);
    assign o_tx_done       = tx_done_reg;
    assign o_tx_byte       = tx_byte_reg;
    assign o_tx_byte_start = tx_byte_start_reg;

endmodule

// File: tb/tb_serial_packet_engine.sv
// Self-checking bench for serial_packet_engine (BYTES=4, byte time 100, T=200).
// A transaction-level model predicts every output each cycle; a transmitter
// model answers each byte start with a 100-cycle busy window.
// Define SERIAL_PKT_ECHO_EN for both files to exercise the echo build.

module tb_serial_packet_engine;

    localparam int T    = 200;
    localparam int BUSY = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] rx_word, pkt_word, tx_word;
    logic [7:0]  rx_count, pkt_len, last_len, tx_len, tx_byte;
    logic        pkt_done, tx_start, tx_ready, tx_done, tx_byte_start;
    logic        tx_busy = 1'b0;

    always #5 clk = ~clk;

    serial_packet_engine #(
        .CLOCK_FREQUENCY(1000), .BAUD(100), .BYTES(4), .IDLE_BYTES(2),
        .RESET_WORD(32'h41)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_word(rx_word), .o_rx_count(rx_count), .o_pkt_len(pkt_len),
        .o_pkt_done(pkt_done), .o_pkt_word(pkt_word), .o_last_len(last_len),
        .i_tx_start(tx_start), .i_tx_word(tx_word), .i_tx_len(tx_len),
        .o_tx_ready(tx_ready), .o_tx_done(tx_done), .o_tx_byte(tx_byte),
        .o_tx_byte_start(tx_byte_start), .i_tx_busy(tx_busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    int          cyc;
    bit          m_prev_valid;
    logic [31:0] m_word, m_pkt_word;
    logic [7:0]  m_count, m_len, m_last_len, m_byte;
    int          m_cap_cyc;
    bit          m_done, m_active, m_waiting, m_seen_high, m_bstart, m_tdone;
    logic [7:0]  m_q[$];

    task automatic model_reset();
        cyc = 0; m_prev_valid = 0; m_word = 32'h41; m_count = 0; m_len = 0;
        m_cap_cyc = 0; m_pkt_word = 0; m_last_len = 0; m_done = 0;
        m_active = 0; m_waiting = 0; m_seen_high = 0; m_bstart = 0; m_tdone = 0;
        m_byte = 0; m_q.delete();
    endtask

    // Queue the bytes to send, most significant first.
    task automatic accept(input logic [31:0] w, input logic [7:0] len);
        int n;
        n = (len == 0 || len > 4) ? 4 : int'(len);
        for (int i = n - 1; i >= 0; i--) m_q.push_back(w[8*i +: 8]);
        m_active = 1; m_waiting = 0;
    endtask

    task automatic model_step();
`ifdef SERIAL_PKT_ECHO_EN
        bit prev_done;
        prev_done = m_done;
`endif
        cyc++;
        m_bstart = 0; m_tdone = 0;
        if (!m_active) begin
            if (tx_start) accept(tx_word, tx_len);
`ifdef SERIAL_PKT_ECHO_EN
            else if (prev_done) accept(m_pkt_word, m_last_len);
`endif
        end else if (m_waiting) begin
            if (tx_busy) m_seen_high = 1;
            else if (m_seen_high) begin
                m_waiting = 0;
                if (m_q.size() == 0) begin m_active = 0; m_tdone = 1; end
            end
        end else if (!tx_busy) begin
            m_byte = m_q.pop_front(); m_bstart = 1; m_waiting = 1; m_seen_high = 0;
        end
        m_done = 0;
        if (rx_valid && !m_prev_valid) begin
            m_word = {m_word[23:0], rx_data};
            m_count = m_count + 8'd1;
            if (m_len != 8'hFF) m_len = m_len + 8'd1;
            m_cap_cyc = cyc;
        end else if (m_len != 0 && cyc - m_cap_cyc == T) begin
            m_done = 1; m_pkt_word = m_word; m_last_len = m_len; m_len = 0;
        end
        m_prev_valid = rx_valid;
    endtask

    // Per-cycle compare, 2 time units after the active edge.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (!rst_n) model_reset(); else model_step();
            chk("rx_word", rx_word, m_word);
            chk("rx_count", rx_count, m_count);
            chk("pkt_len", pkt_len, m_len);
            chk("pkt_done", pkt_done, m_done);
            chk("pkt_word", pkt_word, m_pkt_word);
            chk("last_len", last_len, m_last_len);
            chk("tx_ready", tx_ready, !m_active);
            chk("tx_done", tx_done, m_tdone);
            chk("tx_byte_start", tx_byte_start, m_bstart);
            chk("tx_byte", tx_byte, m_byte);
        end
    end

    // ------------------------------------------------ monitors + transmitter
    int         n_done = 0, n_start = 0, n_tdone = 0, busy_cnt = 0;
    logic [7:0] obs[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pkt_done) begin
                    n_done++;
                    $display("pkt closed: len %0d word %h", last_len, pkt_word);
                end
                if (tx_byte_start) begin
                    n_start++; obs.push_back(tx_byte);
                    $display("tx byte %h", tx_byte);
                end
                if (tx_done) begin
                    n_tdone++;
                    $display("tx transfer done");
                end
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_byte_start) begin tx_busy = 1'b1; busy_cnt = BUSY; end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic strobe(input logic [7:0] d, input int hold, input int gap);
        rx_valid = 1'b1; rx_data = d;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_tx(input logic [31:0] w, input logic [7:0] len);
        tx_word = w; tx_len = len; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready(input int bound);
        int k = 0;
        while (!tx_ready && k < bound) begin @(negedge clk); k++; end
        chk("ready wait in bound", tx_ready, 1'b1);
    endtask

    task automatic wait_tdone(input int target, input int bound);
        int k = 0;
        while (n_tdone < target && k < bound) begin @(negedge clk); k++; end
        chk("tx_done wait in bound", (n_tdone >= target), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_bytes(input string name, input int base, input logic [31:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < obs.size()) chk(name, obs[base + i], exp[8*(n-1-i) +: 8]);
            else chk(name, 9'h100, exp[8*(n-1-i) +: 8]);
        end
    endtask

    initial begin
        int d0, s0, t0, b0, k;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tx_start = 1'b0; tx_word = 32'h0; tx_len = 8'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset rx_word", rx_word, 32'h00000041);
        chk("reset rx_count", rx_count, 8'd0);
        chk("reset tx_ready", tx_ready, 1'b1);
        chk("reset pkt_done", pkt_done, 1'b0);

        // Three-byte packet
        d0 = n_done;
        strobe(8'h12, 5, 95); strobe(8'h34, 5, 95); strobe(8'h56, 5, 95);
        repeat (150) @(negedge clk);
        chk("pkt3 rx_word", rx_word, 32'h41123456);
        chk("pkt3 rx_count", rx_count, 8'd3);
        chk("pkt3 last_len", last_len, 8'd3);
        chk("pkt3 pkt_len", pkt_len, 8'd0);
        chk("pkt3 done count", n_done - d0, 1);

        // 256 bytes: count wraps, length saturates; capture on the timeout cycle
        do_reset();
        for (int i = 0; i < 256; i++) strobe(8'(i), 1, 1);
        chk("wrap rx_count", rx_count, 8'd0);
        chk("sat pkt_len", pkt_len, 8'd255);
        chk("wrap rx_word", rx_word, 32'hFCFDFEFF);
        d0 = n_done;
        strobe(8'h77, 1, T - 1);
        strobe(8'h88, 1, T + 50);
        chk("collide done count", n_done - d0, 1);
        chk("collide last_len", last_len, 8'd255);
        chk("collide pkt_word", pkt_word, 32'hFEFF7788);

        // TX full word with an ignored mid-transfer start
        wait_ready(2000);
        b0 = obs.size(); s0 = n_start; t0 = n_tdone;
        send_tx(32'hA1B2C3D4, 8'd0);
        repeat (150) @(negedge clk);
        send_tx(32'h11223344, 8'd1);
        wait_tdone(t0 + 1, 2000);
        chk("tx4 starts", n_start - s0, 4);
        chk("tx4 dones", n_tdone - t0, 1);
        chk_bytes("tx4 byte", b0, 32'hA1B2C3D4, 4);

        b0 = obs.size(); s0 = n_start; t0 = n_tdone;
        send_tx(32'hA1B2C3D4, 8'd2);
        wait_tdone(t0 + 1, 2000);
        chk("tx2 starts", n_start - s0, 2);
        chk_bytes("tx2 byte", b0, 32'h0000C3D4, 2);

        b0 = obs.size(); s0 = n_start; t0 = n_tdone;
        send_tx(32'h01020304, 8'd9);
        wait_tdone(t0 + 1, 2000);
        chk("tx9 starts", n_start - s0, 4);
        chk_bytes("tx9 byte", b0, 32'h01020304, 4);

        // Reset during the second byte
        s0 = n_start; k = 0;
        send_tx(32'hA1B2C3D4, 8'd0);
        while (n_start - s0 < 2 && k < 1000) begin @(negedge clk); k++; end
        chk("reach byte 2", n_start - s0, 2);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset tx_ready", tx_ready, 1'b1);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("after reset starts", n_start - s0, 2);

        // Packet 55,AA: echoed only in the echo build
        do_reset();
        b0 = obs.size(); s0 = n_start;
        strobe(8'h55, 3, 97); strobe(8'hAA, 3, 97);
        repeat (600) @(negedge clk);
        chk("echo pkt_word", pkt_word, 32'h004155AA);
        chk("echo last_len", last_len, 8'd2);
`ifdef SERIAL_PKT_ECHO_EN
        chk("echo starts", n_start - s0, 2);
        chk_bytes("echo byte", b0, 32'h000055AA, 2);
`else
        chk("no echo starts", n_start - s0, 0);
`endif

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0)
                strobe(8'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 260)));
            else begin
                send_tx($urandom, 8'($urandom_range(0, 10)));
                repeat ($urandom_range(1, 50)) @(negedge clk);
            end
        end
        wait_ready(3000);
        repeat (300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
